axis_block_stream_unit: RTL and testbench

Single-clock AXI-Stream processing element that reduces or expands a data stream. It has one input handshake and one output handshake. A `MODE` parameter selects the function:

- **ACC**: sum every block of 2^ELEMENT_COUNT_LOG samples into one result.
- **AVG**: output the power-of-two average of each block.
- **REP**: emit each input sample NUMBER_OF_REPETITIONS times.

It sits between stream sources and sinks in the compression datapath, e.g. block-mean computation and per-band value broadcast.

---
 rtl/axis_stream_unit_pkg.sv | 25 ++
 rtl/block_sum_core.sv | 84 ++++++++
 rtl/axis_block_stream_unit.sv | 114 +++++++++++
 tb/tb_axis_block_stream_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stream_unit_pkg.sv
// rtl/axis_stream_unit_pkg.sv - shared types and width helper for the block stream unit
package axis_stream_unit_pkg;

    typedef enum logic [1:0] {
        MODE_ACC = 2'd0,
        MODE_AVG = 2'd1,
        MODE_REP = 2'd2
    } stream_mode_t;

    typedef enum logic {
        ST_SUM  = 1'b0,
        ST_EMIT = 1'b1
    } sum_state_t;

    typedef enum logic {
        REP_EMPTY = 1'b0,
        REP_FULL  = 1'b1
    } rep_state_t;

    // Only the accumulate mode widens the result; average and repeat keep sample width.
    function automatic int out_width(input int mode, input int dw, input int log_n);
        return (mode == int'(MODE_ACC)) ? dw + log_n : dw;
    endfunction

endpackage

// File: rtl/block_sum_core.sv
// rtl/block_sum_core.sv - SUM/EMIT block accumulator shared by the ACC and AVG modes
module block_sum_core
    import axis_stream_unit_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int ELEMENT_COUNT_LOG = 8,
    parameter int IS_SIGNED         = 0,
    parameter int ACC_WIDTH         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [ACC_WIDTH-1:0]  output_sum
);

    sum_state_t                   r_state;
    sum_state_t                   w_state_next;
    logic [ACC_WIDTH-1:0]         r_acc;
    logic [ACC_WIDTH-1:0]         r_sum;
    logic [ELEMENT_COUNT_LOG-1:0] r_count;
    logic [ACC_WIDTH-1:0]         w_sample_ext;
    logic [ACC_WIDTH-1:0]         w_acc_plus;
    logic                         w_in_xfer;
    logic                         w_last;

    assign w_sample_ext = {{(ACC_WIDTH-DATA_WIDTH){(IS_SIGNED != 0) && input_data[DATA_WIDTH-1]}},
                           input_data};
    assign w_acc_plus   = r_acc + w_sample_ext;
    assign w_last       = (r_count == '1);
    assign w_in_xfer    = input_valid && input_ready;
    assign output_sum   = r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        case (r_state)
            ST_SUM: begin
                input_ready = 1'b1;
                if (input_valid && w_last) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    w_state_next = ST_SUM;
                end
            end
            default: w_state_next = ST_SUM;
        endcase
    end

    // The final sample goes straight into the result so the accumulator restarts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_in_xfer) begin
            if (w_last) begin
                r_sum   <= w_acc_plus;
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= w_acc_plus;
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_block_stream_unit.sv
// rtl/axis_block_stream_unit.sv - stream block accumulate / average / repeat element
module axis_block_stream_unit
    import axis_stream_unit_pkg::*;
#(
    parameter int MODE                  = 0,
    parameter int DATA_WIDTH            = 16,
    parameter int ELEMENT_COUNT_LOG     = 8,
    parameter int IS_SIGNED             = 0,
    parameter int NUMBER_OF_REPETITIONS = 7,
    localparam int OUT_WIDTH = out_width(MODE, DATA_WIDTH, ELEMENT_COUNT_LOG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [OUT_WIDTH-1:0]  output_data
);

    if (MODE == int'(MODE_REP)) begin : g_rep
        localparam int REP_W = (NUMBER_OF_REPETITIONS > 1) ? $clog2(NUMBER_OF_REPETITIONS) : 1;
        localparam logic [REP_W-1:0] REP_LAST = REP_W'(NUMBER_OF_REPETITIONS - 1);

        rep_state_t            r_state;
        rep_state_t            w_state_next;
        logic [DATA_WIDTH-1:0] r_hold;
        logic [REP_W-1:0]      r_rep;
        logic                  w_last;
        logic                  w_in_xfer;
        logic                  w_out_xfer;

        assign w_last      = (r_rep == REP_LAST);
        assign w_in_xfer   = input_valid && input_ready;
        assign w_out_xfer  = output_valid && output_ready;
        assign output_data = r_hold;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= REP_EMPTY;
            end else begin
                r_state <= w_state_next;
            end
        end

        // A new sample is taken only alongside the last copy, so the hold register
        // never changes while an earlier copy is still owed downstream.
        always_comb begin
            w_state_next = r_state;
            input_ready  = 1'b0;
            output_valid = 1'b0;
            case (r_state)
                REP_EMPTY: begin
                    input_ready = 1'b1;
                    if (input_valid) begin
                        w_state_next = REP_FULL;
                    end
                end
                REP_FULL: begin
                    output_valid = 1'b1;
                    input_ready  = w_last && output_ready;
                    if (w_last && output_ready && !input_valid) begin
                        w_state_next = REP_EMPTY;
                    end
                end
                default: w_state_next = REP_EMPTY;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_hold <= '0;
                r_rep  <= '0;
            end else if (w_in_xfer) begin
                r_hold <= input_data;
                r_rep  <= '0;
            end else if (w_out_xfer) begin
                r_rep  <= w_last ? '0 : r_rep + 1'b1;
            end
        end
    end else begin : g_sum
        localparam int ACC_WIDTH = OUT_WIDTH + ELEMENT_COUNT_LOG;

        logic [ACC_WIDTH-1:0] w_sum;
        logic                 w_unused_sum_bits;

        block_sum_core #(
            .DATA_WIDTH        (DATA_WIDTH),
            .ELEMENT_COUNT_LOG (ELEMENT_COUNT_LOG),
            .IS_SIGNED         (IS_SIGNED),
            .ACC_WIDTH         (ACC_WIDTH)
        ) u_core (
            .clk          (clk),
            .rst          (rst),
            .input_valid  (input_valid),
            .input_ready  (input_ready),
            .input_data   (input_data),
            .output_valid (output_valid),
            .output_ready (output_ready),
            .output_sum   (w_sum)
        );

        if (MODE == int'(MODE_AVG)) begin : g_avg
            // Taking the bits above the shift is floor division for both signednesses.
            assign output_data       = w_sum[ELEMENT_COUNT_LOG +: OUT_WIDTH];
            assign w_unused_sum_bits = ^w_sum[ELEMENT_COUNT_LOG-1:0];
        end else begin : g_acc
            assign output_data       = w_sum[OUT_WIDTH-1:0];
            assign w_unused_sum_bits = ^w_sum[ACC_WIDTH-1:OUT_WIDTH];
        end
    end

endmodule

// File: tb/tb_axis_block_stream_unit.sv
// tb/tb_axis_block_stream_unit.sv - directed and table-driven bench for axis_block_stream_unit
module tb_axis_block_stream_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    logic        acc_iv, acc_ir, acc_ov, acc_or;
    logic [15:0] acc_id;
    logic [23:0] acc_od;
    logic        avg_iv, avg_ir, avg_ov, avg_or;
    logic [15:0] avg_id, avg_od;
    logic        avs_iv, avs_ir, avs_ov, avs_or;
    logic [15:0] avs_id, avs_od;
    logic        rep_iv, rep_ir, rep_ov, rep_or;
    logic [15:0] rep_id, rep_od;
    logic        acs_iv, acs_ir, acs_ov, acs_or;
    logic [7:0]  acs_id;
    logic [9:0]  acs_od;

    axis_block_stream_unit #(.MODE(0), .DATA_WIDTH(16), .ELEMENT_COUNT_LOG(8), .IS_SIGNED(0)) u_acc (
        .clk(clk), .rst(rst_n), .input_valid(acc_iv), .input_ready(acc_ir), .input_data(acc_id),
        .output_valid(acc_ov), .output_ready(acc_or), .output_data(acc_od));
    axis_block_stream_unit #(.MODE(1), .DATA_WIDTH(16), .ELEMENT_COUNT_LOG(8), .IS_SIGNED(0)) u_avg (
        .clk(clk), .rst(rst_n), .input_valid(avg_iv), .input_ready(avg_ir), .input_data(avg_id),
        .output_valid(avg_ov), .output_ready(avg_or), .output_data(avg_od));
    axis_block_stream_unit #(.MODE(1), .DATA_WIDTH(16), .ELEMENT_COUNT_LOG(1), .IS_SIGNED(1)) u_avs (
        .clk(clk), .rst(rst_n), .input_valid(avs_iv), .input_ready(avs_ir), .input_data(avs_id),
        .output_valid(avs_ov), .output_ready(avs_or), .output_data(avs_od));
    axis_block_stream_unit #(.MODE(2), .DATA_WIDTH(16), .NUMBER_OF_REPETITIONS(7)) u_rep (
        .clk(clk), .rst(rst_n), .input_valid(rep_iv), .input_ready(rep_ir), .input_data(rep_id),
        .output_valid(rep_ov), .output_ready(rep_or), .output_data(rep_od));
    axis_block_stream_unit #(.MODE(0), .DATA_WIDTH(8), .ELEMENT_COUNT_LOG(2), .IS_SIGNED(1)) u_acs (
        .clk(clk), .rst(rst_n), .input_valid(acs_iv), .input_ready(acs_ir), .input_data(acs_id),
        .output_valid(acs_ov), .output_ready(acs_or), .output_data(acs_od));

    typedef struct {
        logic [7:0] s0, s1, s2, s3;
        logic [9:0] exp_sum;
    } acs_vec_t;

    typedef struct {
        logic [15:0] a, b;
        logic [15:0] exp_avg;
    } avs_vec_t;

    acs_vec_t acs_tab [6];
    avs_vec_t avs_tab [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acs_send(input logic [7:0] d);
        int w;
        w = 0;
        acs_iv = 1'b1;
        acs_id = d;
        while (!acs_ir && w < 50) begin
            tick();
            w++;
        end
        check("acs_ready_wait", 32'(acs_ir), 32'd1);
        tick();
        acs_iv = 1'b0;
    endtask

    task automatic avs_send(input logic [15:0] d);
        int w;
        w = 0;
        avs_iv = 1'b1;
        avs_id = d;
        while (!avs_ir && w < 50) begin
            tick();
            w++;
        end
        check("avs_ready_wait", 32'(avs_ir), 32'd1);
        tick();
        avs_iv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int ir_low;
        logic [15:0] exp_d;

        acs_tab[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 10'h00A};
        acs_tab[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h3FC};
        acs_tab[2] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 10'h1FC};
        acs_tab[3] = '{8'h80, 8'h80, 8'h80, 8'h80, 10'h200};
        acs_tab[4] = '{8'h64, 8'hCE, 8'hCE, 8'h00, 10'h000};
        acs_tab[5] = '{8'h80, 8'h7F, 8'h05, 8'hFD, 10'h001};

        avs_tab[0] = '{16'hFFFF, 16'hFFFE, 16'hFFFE};
        avs_tab[1] = '{16'h0003, 16'h0004, 16'h0003};
        avs_tab[2] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        avs_tab[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
        avs_tab[4] = '{16'h8000, 16'h8000, 16'h8000};
        avs_tab[5] = '{16'h8000, 16'h7FFF, 16'hFFFF};
        avs_tab[6] = '{16'h000A, 16'hFFFD, 16'h0003};

        {acc_iv, avg_iv, avs_iv, rep_iv, acs_iv} = '0;
        {acc_or, avg_or, avs_or, rep_or, acs_or} = '0;
        acc_id = '0; avg_id = '0; avs_id = '0; rep_id = '0; acs_id = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) tick();
        check("reset_valid_all", 32'({acc_ov, avg_ov, avs_ov, rep_ov, acs_ov}), 32'd0);
        check("reset_acc_data", 32'(acc_od), 32'd0);
        check("reset_rep_data", 32'(rep_od), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'({acc_ir, avg_ir, avs_ir, rep_ir, acs_ir}), 32'h1F);

        // ACC and AVG, 0..255 back to back
        acc_or = 1'b1;
        avg_or = 1'b1;
        ir_low = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            acc_iv = 1'b1; acc_id = 16'(i);
            avg_iv = 1'b1; avg_id = 16'(i);
            if (!acc_ir || !avg_ir) ir_low++;
            if (acc_ov || avg_ov) bad++;
            tick();
        end
        acc_iv = 1'b0;
        avg_iv = 1'b0;
        check("ramp_ready_high", 32'(ir_low), 32'd0);
        check("ramp_no_early_valid", 32'(bad), 32'd0);
        check("acc_ramp_valid", 32'(acc_ov), 32'd1);
        check("acc_ramp_sum", 32'(acc_od), 32'd32640);
        check("avg_ramp_valid", 32'(avg_ov), 32'd1);
        check("avg_ramp_avg", 32'(avg_od), 32'd127);
        check("acc_ready_low_emit", 32'(acc_ir), 32'd0);
        tick();
        check("acc_valid_drops", 32'(acc_ov), 32'd0);
        check("acc_ready_back", 32'(acc_ir), 32'd1);

        // Backpressure with max samples, result held for 10 cycles
        acc_or = 1'b0;
        avg_or = 1'b0;
        for (int i = 0; i < 256; i++) begin
            acc_iv = 1'b1; acc_id = 16'hFFFF;
            avg_iv = 1'b1; avg_id = 16'hFFFF;
            tick();
        end
        acc_iv = 1'b0;
        avg_iv = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(acc_ov === 1'b1 && acc_od === 24'hFFFF00 && acc_ir === 1'b0)) bad++;
            if (!(avg_ov === 1'b1 && avg_od === 16'hFFFF && avg_ir === 1'b0)) bad++;
            tick();
        end
        check("backpressure_hold_bad_cycles", 32'(bad), 32'd0);
        check("acc_max_sum", 32'(acc_od), 32'hFFFF00);
        acc_or = 1'b1;
        avg_or = 1'b1;
        tick();
        check("backpressure_release", 32'({acc_ov, avg_ov}), 32'd0);

        // Signed ACC, LOG=2, table vectors
        acs_or = 1'b1;
        for (int v = 0; v < 6; v++) begin
            acs_send(acs_tab[v].s0);
            acs_send(acs_tab[v].s1);
            acs_send(acs_tab[v].s2);
            acs_send(acs_tab[v].s3);
            check($sformatf("acs_vec%0d_valid", v), 32'(acs_ov), 32'd1);
            check($sformatf("acs_vec%0d_sum", v), 32'(acs_od), 32'(acs_tab[v].exp_sum));
        end

        // Upstream gaps of 10 cycles do not disturb the running sum
        tick();
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            acs_send((k == 0) ? 8'd10 : (k == 1) ? 8'd20 : (k == 2) ? 8'd30 : 8'hFB);
            if (k < 3) begin
                for (int g = 0; g < 10; g++) begin
                    if (acs_ov !== 1'b0 || acs_ir !== 1'b1) bad++;
                    tick();
                end
            end
        end
        check("gap_no_valid", 32'(bad), 32'd0);
        check("gap_sum_valid", 32'(acs_ov), 32'd1);
        check("gap_sum", 32'(acs_od), 32'h037);

        // Signed AVG, LOG=1, table vectors
        avs_or = 1'b1;
        for (int v = 0; v < 7; v++) begin
            avs_send(avs_tab[v].a);
            avs_send(avs_tab[v].b);
            check($sformatf("avs_vec%0d_valid", v), 32'(avs_ov), 32'd1);
            check($sformatf("avs_vec%0d_avg", v), 32'(avs_od), 32'(avs_tab[v].exp_avg));
        end

        // REP: 5 then 6, seven copies each, no bubble
        rep_or = 1'b1;
        rep_iv = 1'b1;
        rep_id = 16'd5;
        tick();
        rep_id = 16'd6;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            exp_d = (k < 7) ? 16'd5 : 16'd6;
            if (rep_ov !== 1'b1 || rep_od !== exp_d) bad++;
            if (rep_ir !== ((k == 6) || (k == 13))) bad++;
            if (k == 6) check("rep_accept_on_7th", 32'(rep_ir), 32'd1);
            tick();
            if (k == 6) rep_iv = 1'b0;
        end
        check("rep_stream_bad", 32'(bad), 32'd0);
        check("rep_empty_after", 32'({rep_ov, rep_ir}), 32'b01);

        // REP under backpressure, including a stalled last copy
        rep_or = 1'b0;
        rep_iv = 1'b1;
        rep_id = 16'h0009;
        tick();
        rep_id = 16'h000A;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (rep_ov !== 1'b1 || rep_od !== 16'h0009 || rep_ir !== 1'b0) bad++;
            tick();
        end
        rep_or = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (rep_od !== 16'h0009 || rep_ir !== 1'b0) bad++;
            tick();
        end
        rep_or = 1'b0;
        #1;
        check("rep_stall_bad", 32'(bad), 32'd0);
        check("rep_last_ready_follows_or", 32'({rep_ir, rep_ov}), 32'b01);
        tick();
        check("rep_last_hold_data", 32'(rep_od), 32'h0009);
        rep_or = 1'b1;
        #1;
        check("rep_last_ready_high", 32'(rep_ir), 32'd1);
        tick();
        rep_iv = 1'b0;
        check("rep_next_loaded", 32'({rep_ov, rep_od}), 32'h1000A);

        // Reset mid-block: ACC partial sum and pending REP copies discarded
        for (int i = 0; i < 100; i++) begin
            acc_iv = 1'b1;
            acc_id = 16'd1;
            tick();
        end
        acc_iv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 32'({acc_ov, rep_ov}), 32'd0);
        check("midreset_data", 32'({acc_od, rep_od[7:0]}), 32'd0);
        tick();
        check("midreset_valid_held", 32'({acc_ov, rep_ov}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            acc_iv = 1'b1;
            acc_id = 16'(i);
            tick();
        end
        acc_iv = 1'b0;
        check("postreset_valid", 32'(acc_ov), 32'd1);
        check("postreset_sum", 32'(acc_od), 32'd32640);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
